adder_8bit: RTL and testbench
=============================

// Module: adder_8bit
// PURPOSE
//  - Two-stage pipelined 8-bit adder with carry-in/carry-out: {cout,dout} = din_1 + din_2 + cin.
//  - Carry-ripple split at nibble boundary: low nibble in stage 1, high nibble in stage 2.
//  - Datapath building block for pipeline experiments; full throughput, one new operand set per clock.
// PARAMETERS
//  - WIDTH  8  operand/result width; fixed at 8, other values unsupported.
//  - SPLIT  4  bit position of stage boundary; low part = [SPLIT-1:0], high part = [WIDTH-1:SPLIT].
// PORTS
//  - clk    in   1  clock, all state on rising edge.
//  - rst    in   1  asynchronous, active-high reset.
//  - din_1  in   8  operand A, unsigned.
//  - din_2  in   8  operand B, unsigned.
//  - cin    in   1  carry in, weight 1.
//  - dout   out  8  registered sum bits [7:0].
//  - cout   out  1  registered carry out (sum bit 8).
//  - One clock; reset is asynchronous and active-high.
// BEHAVIOUR
//  - Stage 1 (edge N): reg s1_lo = din_1[3:0]+din_2[3:0]+cin (4 bits), reg s1_c = its carry;
//    reg s1_a_hi = din_1[7:4], s1_b_hi = din_2[7:4].
//  - Stage 2 (edge N+1): {cout, dout[7:4]} <= s1_a_hi + s1_b_hi + s1_c; dout[3:0] <= s1_lo.
//  - Latency: inputs sampled at edge N appear on dout/cout after edge N+1 (2 clocks).
//  - Throughput 1/clock; no stall, no handshake; operand sets never interact across stages.
//  - Unsigned modulo-256 result in dout; cout = 1 iff din_1+din_2+cin >= 256.
//  - Wrap: 255+0+1 -> dout=0x00,cout=1; 255+255+1 -> dout=0xFF,cout=1.
//  - Carry crossing nibble: 0x0F+0x01+0 -> dout=0x10,cout=0 (carry via s1_c).
//  - Reset asserted: all stage regs, dout, cout -> 0 immediately, independent of clk.
//  - Reset mid-stream: in-flight results discarded; after release, first valid output is the
//    operand set sampled at first rising edge with rst low, 2 clocks later. Until then dout=0,cout=0.
//  - X on inputs propagates only to that operand set's result; no internal state beyond pipeline.
// CONFIGURATION
//  - ADDER_8BIT_VALID_EN defined: adds ports vin (in,1) and vout (out,1); vin is pipelined
//    alongside data with identical 2-clock latency; vout resets to 0; data regs still load
//    every clock (valid is qualifier only, not enable).
//  - Not defined: no valid ports; outputs considered valid 2 clocks after any sampled input.
// TESTING
//  - Reset: rst=1 with random inputs toggling -> dout=0,cout=0 asynchronously, held while rst=1.
//  - Stream: din_1=0..49, din_2=10..59 incrementing each clock, cin=0 -> dout=10,12,..,108 two clocks later, cout=0.
//  - Nibble carry: din_1=0x0F, din_2=0x01, cin=0 -> dout=0x10, cout=0; with cin=1 -> 0x11.
//  - Overflow: din_1=0xFF,din_2=0x00,cin=1 -> dout=0x00,cout=1; 0xFF+0xFF+1 -> 0xFF,cout=1; 0x80+0x80+0 -> 0x00,cout=1.
//  - Back-to-back: alternate 0xFF+0x01 and 0x01+0x01 every clock -> outputs 0x00/c1, 0x02/c0 alternate, no cross-contamination.
//  - Mid-stream reset pulse (one cycle) -> outputs 0 at once; results resume from first post-reset sample with 2-clock latency;
//    with ADDER_8BIT_VALID_EN, vout tracks vin delayed 2 clocks and is 0 during/after reset until refilled.

Source files
------------

// File: rtl/adder_8bit.sv
// Two-stage pipelined 8-bit adder: the low nibble and its carry are computed in stage 1 and the high nibble in stage 2.
// Optional build macro ADDER_8BIT_VALID_EN adds a vin/vout qualifier that travels with the data.
module adder_8bit #(
    parameter int WIDTH = 8,
    parameter int SPLIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_1,
    input  logic [WIDTH-1:0] din_2,
    input  logic             cin,
`ifdef ADDER_8BIT_VALID_EN
    input  logic             vin,
    output logic             vout,
`endif
    output logic [WIDTH-1:0] dout,
    output logic             cout
);

    localparam int HI_W = WIDTH - SPLIT;

    // Stage 1 combinational: ripple the low part together with cin.
    logic [SPLIT-1:0] lo_sum;
    logic             lo_carry;

    always_comb begin
        lo_sum   = '0;
        lo_carry = cin;
        for (int i = 0; i < SPLIT; i++) begin
            lo_sum[i] = din_1[i] ^ din_2[i] ^ lo_carry;
            lo_carry  = (din_1[i] & din_2[i]) | (lo_carry & (din_1[i] ^ din_2[i]));
        end
    end

    // Stage 1 registers hold the low result and the untouched high operands.
    logic [SPLIT-1:0] s1_lo;
    logic             s1_c;
    logic [HI_W-1:0]  s1_a_hi;
    logic [HI_W-1:0]  s1_b_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_lo   <= '0;
            s1_c    <= 1'b0;
            s1_a_hi <= '0;
            s1_b_hi <= '0;
        end else begin
            s1_lo   <= lo_sum;
            s1_c    <= lo_carry;
            s1_a_hi <= din_1[WIDTH-1:SPLIT];
            s1_b_hi <= din_2[WIDTH-1:SPLIT];
        end
    end

    // Stage 2 combinational: ripple the high part from the registered carry.
    logic [HI_W-1:0] hi_sum;
    logic            hi_carry;

    always_comb begin
        hi_sum   = '0;
        hi_carry = s1_c;
        for (int i = 0; i < HI_W; i++) begin
            hi_sum[i] = s1_a_hi[i] ^ s1_b_hi[i] ^ hi_carry;
            hi_carry  = (s1_a_hi[i] & s1_b_hi[i]) | (hi_carry & (s1_a_hi[i] ^ s1_b_hi[i]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            cout <= 1'b0;
        end else begin
            dout <= {hi_sum, s1_lo};
            cout <= hi_carry;
        end
    end

`ifdef ADDER_8BIT_VALID_EN
    // vin only qualifies the data and never stalls it: every stage loads on every clock,
    // so vout is simply vin delayed by the same two clocks as the sum.
    logic s1_v;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            vout <= 1'b0;
        end else begin
            s1_v <= vin;
            vout <= s1_v;
        end
    end
`endif

endmodule

// File: tb/tb_adder_8bit.sv
// Self-checking bench for adder_8bit: an arithmetic reference model with two-clock delay plus literal spot checks.
// Build with ADDER_8BIT_VALID_EN defined to cover the vin/vout qualifier.
module tb_adder_8bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_1 = '0;
    logic [7:0] din_2 = '0;
    logic       cin = 1'b0;
    logic [7:0] dout;
    logic       cout;
    logic       vin = 1'b0;
`ifdef ADDER_8BIT_VALID_EN
    logic       vout;
`else
    logic       vout;
    assign vout = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_8bit dut (
        .clk   (clk),
        .rst   (rst),
        .din_1 (din_1),
        .din_2 (din_2),
        .cin   (cin),
`ifdef ADDER_8BIT_VALID_EN
        .vin   (vin),
        .vout  (vout),
`endif
        .dout  (dout),
        .cout  (cout)
    );

    // Reference model: the full 9-bit sum of each sampled operand set, shown two edges later.
    logic [8:0] exp_q[$];
    logic       expv_q[$];
    int         samples = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            expv_q.delete();
            samples <= 0;
        end else begin
            exp_q.push_back(9'(din_1) + 9'(din_2) + 9'(cin));
            expv_q.push_back(vin);
            if (exp_q.size() > 2) begin
                void'(exp_q.pop_front());
                void'(expv_q.pop_front());
            end
            samples <= (samples < 2) ? samples + 1 : 2;
        end
    end

    // Compare every cycle on the falling edge; before refill the outputs must be zero.
    always @(negedge clk) begin
        logic [8:0] exp;
        logic       expv;
        exp  = (samples >= 2) ? exp_q[0] : 9'h000;
        expv = (samples >= 2) ? expv_q[0] : 1'b0;
        tests++;
        if ({cout, dout} !== exp) begin
            fails++;
            $display("FAIL model_sum t=%0t got cout=%b dout=%02h want cout=%b dout=%02h",
                     $time, cout, dout, exp[8], exp[7:0]);
        end
`ifdef ADDER_8BIT_VALID_EN
        tests++;
        if (vout !== expv) begin
            fails++;
            $display("FAIL model_vout t=%0t got %b want %b", $time, vout, expv);
        end
`endif
    end

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic c, input logic v);
        @(negedge clk);
        din_1 = a;
        din_2 = b;
        cin   = c;
        vin   = v;
    endtask

    // Hand-computed expectation: hold one operand set, then look after two edges.
    task automatic check_lit(input string name, input logic [7:0] a, input logic [7:0] b,
                             input logic c, input logic [7:0] ed, input logic ec);
        drive(a, b, c, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        tests++;
        if (dout !== ed || cout !== ec) begin
            fails++;
            $display("FAIL %s got dout=%02h cout=%b want dout=%02h cout=%b", name, dout, cout, ed, ec);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (dout !== 8'h00 || cout !== 1'b0 || vout !== 1'b0) begin
            fails++;
            $display("FAIL %s got dout=%02h cout=%b vout=%b want all zero", name, dout, cout, vout);
        end
    endtask

    initial begin
        // Reset held with inputs toggling.
        for (int i = 0; i < 6; i++)
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
        #1 check_zero("reset_hold");
        drive(8'd0, 8'd10, 1'b0, 1'b1);
        rst = 1'b0;

        // Incrementing stream: 0..49 plus 10..59.
        for (int i = 1; i < 50; i++) drive(8'(i), 8'(i + 10), 1'b0, 1'b1);

        check_lit("nibble_carry", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        check_lit("nibble_carry_cin", 8'h0F, 8'h01, 1'b1, 8'h11, 1'b0);
        check_lit("wrap_ff_00_1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        check_lit("wrap_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        check_lit("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        check_lit("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Back-to-back alternation.
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) drive(8'hFF, 8'h01, 1'b0, 1'b1);
            else            drive(8'h01, 8'h01, 1'b0, 1'b0);
        end

        // Random traffic with a random qualifier.
        for (int i = 0; i < 300; i++)
            drive(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Mid-stream one-cycle reset pulse: outputs clear at once, then refill.
        drive(8'hAA, 8'h55, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset_pulse");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++)
            drive(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
